stable_timer_unit: RTL
======================

Name: stable_timer_unit

Overview:
- Parametrised successor to the core's free-running stable counter.
- Provides a wide stable counter readable as low/high 32-bit halves, a constant counter ID, and a programmable countdown timer with one-shot and periodic modes.
- The countdown timer drives a level timer interrupt, cleared by software.
- Sits beside the CSR file: serves the rdcntvl/rdcntvh/rdcntid reads and the TCFG/TVAL/TICLR CSR accesses.

Parameters:
- CNT_W, 64, stable counter width; legal 33..64.
- TVAL_W, 32, timer config/countdown width; legal 3..32.
- COUNTER_ID, 32'h0, constant returned on rd_sel=2'b10.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- cnt_en  in  1  stable counter increment enable; 0 freezes the counter
- rd_sel  in  2  read select: 00 counter[31:0], 01 counter[CNT_W-1:32] zero-extended, 10 COUNTER_ID, 11 tval zero-extended
- rd_value  out  32  combinational read data for rd_sel
- tcfg_we  in  1  TCFG write strobe
- tcfg_wdata  in  TVAL_W  bit0 En, bit1 Periodic, [TVAL_W-1:2] InitVal
- ticlr_we  in  1  TICLR write strobe
- ticlr_wdata  in  1  1 clears timer_int
- tcfg  out  TVAL_W  current TCFG register
- tval  out  TVAL_W  current countdown value
- timer_int  out  1  timer interrupt, level, registered

Behaviour:
- Reset values: counter=0, tcfg=0, tval=0, timer_en=0, timer_int=0. Reset wins over every concurrent event, including mid-countdown.
- Stable counter:
  - Increments by 1 each cycle while cnt_en=1.
  - Wraps from all-ones to 0 with no flag.
  - Unaffected by any timer activity.
- Reads:
  - rd_value is combinational from the current register state.
  - A read in the same cycle as a write returns the pre-write value.
- TCFG write (tcfg_we=1), at the clock edge:
  - tcfg <= tcfg_wdata.
  - tval <= {InitVal, 2'b00}.
  - timer_en <= En.
  - timer_int is unchanged.
- Countdown, evaluated each edge when no TCFG write is present:
  - timer_en=1 and tval!=0: tval <= tval-1.
  - timer_en=1 and tval==0 (expiry): timer_int <= 1.
    - Periodic=1: tval <= {InitVal, 2'b00}; timer_en stays 1.
    - Periodic=0: timer_en <= 0; tval holds 0.
  - timer_en=0: tval holds.
- Latency: a TCFG write with InitVal=N, En=1 at edge E0 gives tval=4N after E0. Expiry is at edge E0+4N+1; timer_int reads 1 after that edge.
- Periodic period: 4N+1 cycles between successive expiries.
- InitVal=0, Periodic=1: expiry on every edge; timer_int is held at 1.
- TICLR: ticlr_we=1 with ticlr_wdata=1 gives timer_int <= 0 at the edge. ticlr_wdata=0 has no effect.
- Simultaneous events:
  - Expiry and TICLR clear in the same cycle: set wins, timer_int=1.
  - TCFG write and expiry in the same cycle: the write wins for tcfg/tval/timer_en; that expiry is discarded and timer_int keeps its prior value.
  - TCFG write and TICLR in the same cycle: both take effect.
- Writing En=0 mid-count stops the countdown and reloads tval to {InitVal, 2'b00}. A pending timer_int remains set.
- Arithmetic: tval subtraction is TVAL_W wide and never underflows (guarded by tval!=0).
- rd_sel=01: with CNT_W<64, upper bits of the 32-bit result are 0.

Test Plan:
- Reset, cnt_en=1 for 10 cycles -> rd_sel=00 returns 10, rd_sel=01 returns 0; reset asserted once more -> both 0.
- Preload counter via force to 64'h0000_0000_FFFF_FFFE, run 3 cycles -> low=1, high=1. Then all-ones +1 -> low=0, high=0 (wrap).
- TCFG write En=1, Periodic=0, InitVal=2 -> tval 8..0; timer_int=1 exactly 9 edges after the write; tval stays 0; no re-fire after TICLR.
- Periodic, InitVal=1 -> timer_int sets every 5 cycles. Each TICLR clear is followed by a re-set 5 cycles after the previous expiry. TICLR on the expiry cycle -> timer_int stays 1.
- TCFG write on the expiry cycle -> tval reloads to the new 4*InitVal and timer_int is not newly set. En=0 write mid-count -> tval frozen at the reload value, timer_int never asserts.
- rd_sel=10 with COUNTER_ID=32'h5 -> 5. Parameter sweep CNT_W=48, TVAL_W=16 -> high half correctly zero-extended, countdown correct.

Source files
------------

// File: rtl/stable_timer_unit.sv
// Stable counter plus programmable countdown timer.
// Serves the rdcntvl/rdcntvh/rdcntid reads and the TCFG/TVAL/TICLR accesses
// that sit beside the CSR file.
module stable_timer_unit #(
    parameter int          CNT_W      = 64,
    parameter int          TVAL_W     = 32,
    parameter logic [31:0] COUNTER_ID = 32'h0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cnt_en,
    input  logic [1:0]        rd_sel,
    output logic [31:0]       rd_value,
    input  logic              tcfg_we,
    input  logic [TVAL_W-1:0] tcfg_wdata,
    input  logic              ticlr_we,
    input  logic              ticlr_wdata,
    output logic [TVAL_W-1:0] tcfg,
    output logic [TVAL_W-1:0] tval,
    output logic              timer_int
);

    logic [CNT_W-1:0]  counter;
    logic [TVAL_W-1:0] tcfg_q;
    logic [TVAL_W-1:0] tval_q;
    logic              timer_en;
    logic              timer_int_q;

    logic [TVAL_W-1:0] tcfg_d;
    logic [TVAL_W-1:0] tval_d;
    logic              timer_en_d;
    logic              timer_int_d;

    logic [TVAL_W-1:0] wr_reload;
    logic [TVAL_W-1:0] per_reload;
    logic              expire;
    logic [31:0]       cnt_hi;
    logic [31:0]       tval_ext;

    // InitVal counts in units of four cycles, so reloads append two zero bits.
    assign wr_reload  = {tcfg_wdata[TVAL_W-1:2], 2'b00};
    assign per_reload = {tcfg_q[TVAL_W-1:2], 2'b00};
    assign expire     = timer_en && (tval_q == '0);

    // Zero-extend the upper counter half; a full 64-bit counter needs no padding.
    generate
        if (CNT_W == 64) begin : g_hi_full
            assign cnt_hi = counter[63:32];
        end else begin : g_hi_pad
            assign cnt_hi = {{(64-CNT_W){1'b0}}, counter[CNT_W-1:32]};
        end
        if (TVAL_W == 32) begin : g_tval_full
            assign tval_ext = tval_q;
        end else begin : g_tval_pad
            assign tval_ext = {{(32-TVAL_W){1'b0}}, tval_q};
        end
    endgenerate

    // Free-running stable counter, wraps silently, independent of the timer.
    always_ff @(posedge clk) begin
        if (reset) begin
            counter <= '0;
        end else if (cnt_en) begin
            counter <= counter + CNT_W'(1);
        end
    end

    // Read mux works from current register state, so same-cycle writes are not visible.
    always_comb begin
        rd_value = 32'h0;
        case (rd_sel)
            2'b00:   rd_value = counter[31:0];
            2'b01:   rd_value = cnt_hi;
            2'b10:   rd_value = COUNTER_ID;
            default: rd_value = tval_ext;
        endcase
    end

    // Timer next state: a TCFG write overrides the countdown and swallows any
    // coincident expiry; an expiry set beats a same-cycle TICLR clear.
    always_comb begin
        tcfg_d      = tcfg_q;
        tval_d      = tval_q;
        timer_en_d  = timer_en;
        timer_int_d = timer_int_q;

        if (ticlr_we && ticlr_wdata) begin
            timer_int_d = 1'b0;
        end

        if (tcfg_we) begin
            tcfg_d     = tcfg_wdata;
            tval_d     = wr_reload;
            timer_en_d = tcfg_wdata[0];
        end else if (timer_en) begin
            if (tval_q != '0) begin
                tval_d = tval_q - TVAL_W'(1);
            end else begin
                timer_int_d = 1'b1;
                if (tcfg_q[1]) begin
                    tval_d = per_reload;
                end else begin
                    timer_en_d = 1'b0;
                end
            end
        end
    end

    // Timer state registers; reset beats every concurrent event.
    always_ff @(posedge clk) begin
        if (reset) begin
            tcfg_q      <= '0;
            tval_q      <= '0;
            timer_en    <= 1'b0;
            timer_int_q <= 1'b0;
        end else begin
            tcfg_q      <= tcfg_d;
            tval_q      <= tval_d;
            timer_en    <= timer_en_d;
            timer_int_q <= timer_int_d;
        end
    end

    assign tcfg      = tcfg_q;
    assign tval      = tval_q;
    assign timer_int = timer_int_q;

    // Not yet consumed anywhere but kept visible for debug probes.
    logic unused_expire;
    assign unused_expire = expire;

endmodule
